uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter, the send-side counterpart of the UART receive path and its 7-segment display decoder. It accepts one 8-bit byte per strobe from user logic and emits a standard asynchronous frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits between the board-level control logic and the TX pin. It reports `tx_busy` while a frame is in flight and pulses `tx_done` when the frame completes.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after bit 7; 0 omits it.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tx_start`  in  1  request to send `tx_data`; sampled only when `tx_busy`=0.
- `tx_data`  in  8  byte to send; captured on the accepting edge.
- `tx`  out  1  serial line, idle high; registered.
- `tx_busy`  out  1  high from the cycle after acceptance until frame end.
- `tx_done`  out  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `tx_start`=1, the block captures `tx_data` into a shift register, computes parity as the XOR of the 8 bits, clears the bit counter and the baud counter, and moves to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx`=shift[0]. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit index 7, the FSM goes to PARITY if PARITY_EN=1, else to STOP.
- PARITY: `tx`=parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle the FSM returns to IDLE, `tx_busy` drops, and `tx_done` pulses.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1, wraps to 0, and asserts a bit-end tick on the terminal count. It is held at 0 in IDLE.
- Bit counter: 3 bits, valid range 0..7. It increments only on a bit-end tick in DATA.
- `tx_start` while busy is ignored. The request is not queued, and `tx_data` changes mid-frame have no effect.
- `tx_start` held high continuously sends back-to-back frames, re-capturing `tx_data` on each IDLE cycle.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0, shift register 0.
- Reset mid-frame: at the next edge with `rst_n`=0, `tx` returns to 1 and the frame is aborted. No `tx_done` pulse is produced.
- Acceptance at edge E0. From E0, `tx`=0 and `tx_busy`=1.
- Frame length: F = (10 + PARITY_EN) × CLKS_PER_BIT cycles from the falling edge of `tx` to the edge where `tx_busy` falls.
- `tx_done`=1 for exactly the one cycle in which the FSM is back in IDLE. In that same cycle `tx_start` may be accepted.
- Minimum start-to-start spacing is therefore F + 1 cycles, because one IDLE cycle (`tx`=1) separates frames.
- `tx` changes only on bit boundaries, with no glitches; it is driven from a flop.

## Structure
- Package `uart_pkg` holds the state enum (3-bit encoding), the default CLKS_PER_BIT and the data width constant (8). The receive path shares this package.
- One sub-module, `uart_baud_cnt`, contains the baud counter with enable/clear and a tick output. The receiver reuses it.
- The top level contains the FSM, shift register, bit counter and parity flop.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Send 0x55, PARITY_EN=0 → `tx` shows 0,1,0,1,0,1,0,1,0 then stop 1, each bit for 4 cycles. `tx_busy` stays high for 40 cycles, and `tx_done` pulses once at cycle 40.
- Send 0x07, PARITY_EN=1 → data bits 1,1,1,0,0,0,0,0, then parity 1, then stop. `tx_done` pulses at cycle 44.
- Pulse `tx_start` with 0xA3 at cycle 10 of a 0x55 frame → the 0x55 frame completes unchanged, 0xA3 is never sent, and only one `tx_done` pulse occurs.
- Assert `rst_n`=0 during bit 3 of a frame → `tx`=1 and `tx_busy`=0 on the next edge, and no `tx_done` pulse. A new `tx_start` afterwards sends a complete, correct frame.
- Hold `tx_start`=1 with `tx_data`=0x00, then 0xFF → two frames are sent, separated by exactly one idle-high cycle, with correct bits in each.
- Hold `tx_start`=0 for 100 cycles after reset → `tx` stays 1, and `tx_busy`/`tx_done` stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and default bit timing.
// Imported by both the transmit and receive paths.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_par(
    input logic [DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on
// the terminal count, held at zero by clear.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even
// parity, one stop bit. All outputs come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_q;
  logic              par_q;
  logic              tick;
  logic              idle;

  assign idle = (state_q == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!idle),
    .clr_i (idle),
    .tick_o(tick)
  );

  // tx is loaded one bit ahead at each boundary so the pin never glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shift_q <= tx_data;
            par_q   <= even_par(tx_data);
            bit_q   <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx      <= par_q;
                state_q <= ST_PARITY;
              end else begin
                tx      <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              tx    <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: one instance without and one with parity,
// driven together; line monitors decode frames against a byte queue.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;
  logic       tx_w   [2];
  logic       busy_w [2];
  logic       done_w [2];

  int checks;
  int failures;
  int exp_frames;
  int frames_seen [2];
  int last_gap    [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  assign tx_w[0]   = tx0;
  assign tx_w[1]   = tx1;
  assign busy_w[0] = busy0;
  assign busy_w[1] = busy1;
  assign done_w[0] = done0;
  assign done_w[1] = done1;

  uart_tx #(
    .CLKS_PER_BIT(C),
    .PARITY_EN   (0)
  ) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx0),
    .tx_busy (busy0),
    .tx_done (done0)
  );

  uart_tx #(
    .CLKS_PER_BIT(C),
    .PARITY_EN   (1)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx1),
    .tx_busy (busy1),
    .tx_done (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, int d,
                              logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", nm, d, a, e);
    end
  endfunction

  // Line monitor: frame bits come from the queued byte, never the DUT.
  task automatic mon(input int d);
    int         nb;
    int         gap;
    int         bad;
    int         ones;
    int         sz;
    bit         abort;
    logic [7:0] b;
    logic [11:0] bits;
    logic [C-1:0] smp;
    nb  = 10 + d;
    gap = 0;
    forever begin
      @(negedge clk);
      if (tx_w[d] !== 1'b0) begin
        chk("idle_busy", d, 32'(busy_w[d]), 0);
        chk("idle_done", d, 32'(done_w[d]), 0);
        gap++;
      end else begin
        last_gap[d] = gap;
        gap   = 0;
        abort = 0;
        bad   = 0;
        b     = 8'h00;
        sz    = (d == 0) ? q0.size() : q1.size();
        chk("frame_expected", d, 32'(sz == 0), 0);
        if (sz > 0) b = (d == 0) ? q0.pop_front() : q1.pop_front();
        bits    = '1;
        bits[0] = 1'b0;
        ones    = 0;
        for (int i = 0; i < 8; i++) begin
          bits[i+1] = b[i];
          ones += int'(b[i]);
        end
        if (d == 1) bits[9] = (ones % 2) != 0;
        for (int k = 0; k < nb && !abort; k++) begin
          smp = '0;
          for (int j = 0; j < C && !abort; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            smp[j] = tx_w[d];
            if (busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) bad++;
            if (!rst_n) abort = 1;
          end
          if (!abort)
            chk($sformatf("slot%0d_byte%02h", k, b), d,
                32'(smp), 32'({C{bits[k]}}));
        end
        chk("busy_in_frame", d, 32'(bad), 0);
        @(negedge clk);
        if (abort) begin
          chk("rst_tx", d, 32'(tx_w[d]), 1);
          chk("rst_busy", d, 32'(busy_w[d]), 0);
          chk("rst_done", d, 32'(done_w[d]), 0);
        end else begin
          chk("end_tx", d, 32'(tx_w[d]), 1);
          chk("end_busy", d, 32'(busy_w[d]), 0);
          chk("end_done", d, 32'(done_w[d]), 1);
          frames_seen[d]++;
          gap = 1;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = v;
    q0.push_back(v);
    q1.push_back(v);
    exp_frames++;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk);
    while ((busy0 === 1'b1 || busy1 === 1'b1) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("idle_timeout", 0, 32'(n >= 300), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_frames();
    chk("frames", 0, 32'(frames_seen[0]), 32'(exp_frames));
    chk("frames", 1, 32'(frames_seen[1]), 32'(exp_frames));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_frames  = 0;
    frames_seen = '{0, 0};
    last_gap    = '{0, 0};
    rst_n       = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 0, 32'(tx0), 1);
    chk("reset_busy", 0, 32'(busy0), 0);
    chk("reset_done", 0, 32'(done0), 0);
    chk("reset_tx", 1, 32'(tx1), 1);
    chk("reset_busy", 1, 32'(busy1), 0);
    chk("reset_done", 1, 32'(done1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      mon(0);
      mon(1);
    join_none

    repeat (100) @(posedge clk);
    #1;
    chk_frames();

    send(8'h55);
    repeat (9) @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'hA3;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_idle();
    chk_frames();

    send(8'h07);
    wait_idle();
    chk_frames();

    send(8'h3C);
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_frames--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();
    chk_frames();
    send(8'hC3);
    wait_idle();
    chk_frames();

    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    q0.push_back(8'h00);
    q1.push_back(8'h00);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    q0.push_back(8'hFF);
    q1.push_back(8'hFF);
    exp_frames += 2;
    repeat (45) @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_idle();
    chk_frames();
    chk("b2b_gap", 0, 32'(last_gap[0]), 1);
    chk("b2b_gap", 1, 32'(last_gap[1]), 1);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(8'($urandom));
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
      tx_data = 8'($urandom);
      wait_idle();
    end
    chk_frames();
    chk("queue_left", 0, 32'(q0.size()), 0);
    chk("queue_left", 1, 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
